// File: rtl/ysyx_23060061_core_ctrl.sv
// Multi-cycle control FSM for the NPC core: fetch, execute, memory, writeback.
// Gates IR/RF/PC writes, halts on ebreak, flags handshake timeouts as bus errors.
module ysyx_23060061_core_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   output logic        ir_we,
   input  logic        dec_is_load,
   input  logic        dec_is_store,
   input  logic        dec_reg_write,
   input  logic        dec_ebreak,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   output logic        rf_we,
   output logic        pc_we,
   output logic        halt,
   output logic        bus_err,
   output logic [2:0]  state,
   output logic [31:0] inst_cnt
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_FWAIT = 3'd1,
      S_EXEC  = 3'd2,
      S_MREQ  = 3'd3,
      S_MWAIT = 3'd4,
      S_WB    = 3'd5,
      S_HALT  = 3'd6,
      S_ERR   = 3'd7
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        inst_cnt_q, inst_cnt_d;
   logic               wait_st;
   logic               timed_out;

   assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         cnt_q      <= '0;
         inst_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inst_cnt_q <= inst_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      inst_cnt_d    = inst_cnt_q;
      ifu_req_valid = 1'b0;
      ir_we         = 1'b0;
      lsu_req_valid = 1'b0;
      rf_we         = 1'b0;
      pc_we         = 1'b0;
      wait_st       = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ifu_req_valid = 1'b1;
            wait_st       = 1'b1;
            if (ifu_req_ready)  state_d = S_FWAIT;
            else if (timed_out) state_d = S_ERR;
         end
         S_FWAIT: begin
            ir_we   = ifu_rsp_valid;
            wait_st = 1'b1;
            if (ifu_rsp_valid)  state_d = S_EXEC;
            else if (timed_out) state_d = S_ERR;
         end
         S_EXEC: begin
            if (dec_ebreak) begin
               state_d    = S_HALT;
               inst_cnt_d = inst_cnt_q + 32'd1;
            end else if (dec_is_load && dec_is_store) begin
               state_d = S_ERR;
            end else if (dec_is_load || dec_is_store) begin
               state_d = S_MREQ;
            end else begin
               state_d = S_WB;
            end
         end
         S_MREQ: begin
            lsu_req_valid = 1'b1;
            wait_st       = 1'b1;
            if (lsu_req_ready)  state_d = S_MWAIT;
            else if (timed_out) state_d = S_ERR;
         end
         S_MWAIT: begin
            wait_st = 1'b1;
            if (lsu_rsp_valid)  state_d = S_WB;
            else if (timed_out) state_d = S_ERR;
         end
         S_WB: begin
            rf_we      = dec_reg_write & ~dec_is_store;
            pc_we      = 1'b1;
            inst_cnt_d = inst_cnt_q + 32'd1;
            state_d    = S_FETCH;
         end
         S_HALT, S_ERR: ;
         default: state_d = S_ERR;
      endcase
      // Count only idle wait cycles; any state change restarts the window.
      cnt_d = (state_d != state_q || !wait_st) ? '0 : cnt_q + 1'b1;
   end

   assign halt     = (state_q == S_HALT);
   assign bus_err  = (state_q == S_ERR);
   assign state    = state_q;
   assign inst_cnt = inst_cnt_q;

endmodule
